// File: rtl/target_run_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : target_run_seq                                                |
// | Description : Sequences one Arm target capture run in the usb_clk domain:   |
// |               wait for MMCM lock, pulse target reset, wait for the target   |
// |               trigger, then count the cycles the trigger stays high.        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module target_run_seq #(
  parameter int pCNT_WIDTH   = 32,
  parameter int pRST_WIDTH   = 16,
  parameter int pSYNC_STAGES = 2     // must be at least 2
) (
  input  logic                  usb_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [pRST_WIDTH-1:0] rst_len,
  input  logic [pCNT_WIDTH-1:0] timeout,
  input  logic                  pll_locked,
  input  logic                  trig_in,
  input  logic                  manual_reset,
  output logic                  target_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out,
  output logic [pCNT_WIDTH-1:0] trig_cycles,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RESET     = 3'd2,
    S_WAIT_TRIG = 3'd3,
    S_CAPTURE   = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam logic [pCNT_WIDTH-1:0] C_CNT_ONE = {{(pCNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pRST_WIDTH-1:0] C_RST_ONE = {{(pRST_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [pSYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [pSYNC_STAGES-1:0] trig_sync_q, trig_sync_d;
  logic                    trig_s_q, trig_s_d;
  logic [pCNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  logic [pRST_WIDTH-1:0]   rst_cnt_q, rst_cnt_d;
  logic [pCNT_WIDTH-1:0]   trig_cycles_q, trig_cycles_d;
  logic                    done_q, done_d;
  logic                    timed_out_q, timed_out_d;
  logic                    target_reset_q, target_reset_d;

  logic                    w_lock_s;
  logic                    w_trig_s;
  logic                    w_trig_rise;
  logic                    w_tmo_hit;
  logic [pRST_WIDTH-1:0]   w_rst_load;

  assign w_lock_s    = lock_sync_q[pSYNC_STAGES-1];
  assign w_trig_s    = trig_sync_q[pSYNC_STAGES-1];
  assign w_trig_rise = w_trig_s & ~trig_s_q;
  // A zero timeout never matches, so the run may wait forever.
  assign w_tmo_hit   = (timeout != '0) && (wait_cnt_q == timeout);
  // A zero reset length still yields a one-cycle target reset.
  assign w_rst_load  = (rst_len == '0) ? C_RST_ONE : rst_len;

  // Synchroniser shift chains for the two asynchronous inputs.
  always_comb begin
    lock_sync_d = {lock_sync_q[pSYNC_STAGES-2:0], pll_locked};
    trig_sync_d = {trig_sync_q[pSYNC_STAGES-2:0], trig_in};
    trig_s_d    = w_trig_s;
  end

  // Next-state, counters and sticky status flags for the run sequencer.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    rst_cnt_d     = rst_cnt_q;
    trig_cycles_d = trig_cycles_q;
    done_d        = done_q;
    timed_out_d   = timed_out_q;

    case (state_q)
      S_IDLE: begin
        // abort beats a coincident start: no run, flags untouched
        if (start && !abort) begin
          state_d       = S_WAIT_LOCK;
          done_d        = 1'b0;
          timed_out_d   = 1'b0;
          trig_cycles_d = '0;
          wait_cnt_d    = '0;
        end
      end

      S_WAIT_LOCK: begin
        wait_cnt_d = wait_cnt_q + C_CNT_ONE;
        if (abort) begin
          state_d = S_IDLE;
        end else if (w_tmo_hit) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
        end else if (w_lock_s) begin
          state_d   = S_RESET;
          rst_cnt_d = w_rst_load;
        end
      end

      S_RESET: begin
        // wait_cnt holds here; the reset pulse is not part of the wait
        rst_cnt_d = rst_cnt_q - C_RST_ONE;
        if (abort) begin
          state_d = S_IDLE;
        end else if (rst_cnt_q == C_RST_ONE) begin
          state_d = S_WAIT_TRIG;
        end
      end

      S_WAIT_TRIG: begin
        wait_cnt_d = wait_cnt_q + C_CNT_ONE;
        if (abort) begin
          state_d = S_IDLE;
        end else if (w_trig_rise) begin
          // the trigger wins over a coincident timeout
          state_d       = S_CAPTURE;
          trig_cycles_d = C_CNT_ONE;
        end else if (w_tmo_hit) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
        end
      end

      S_CAPTURE: begin
        wait_cnt_d = wait_cnt_q + C_CNT_ONE;
        if (abort) begin
          state_d = S_IDLE;
        end else if (!w_trig_s) begin
          // normal completion, even if the timeout lands on this edge
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (w_tmo_hit) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
        end else if (!(&trig_cycles_q)) begin
          trig_cycles_d = trig_cycles_q + C_CNT_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    target_reset_d = (state_d == S_RESET) | manual_reset;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      lock_sync_q    <= '0;
      trig_sync_q    <= '0;
      trig_s_q       <= 1'b0;
      wait_cnt_q     <= '0;
      rst_cnt_q      <= '0;
      trig_cycles_q  <= '0;
      done_q         <= 1'b0;
      timed_out_q    <= 1'b0;
      target_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lock_sync_q    <= lock_sync_d;
      trig_sync_q    <= trig_sync_d;
      trig_s_q       <= trig_s_d;
      wait_cnt_q     <= wait_cnt_d;
      rst_cnt_q      <= rst_cnt_d;
      trig_cycles_q  <= trig_cycles_d;
      done_q         <= done_d;
      timed_out_q    <= timed_out_d;
      target_reset_q <= target_reset_d;
    end
  end

  assign target_reset = target_reset_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = done_q;
  assign timed_out    = timed_out_q;
  assign trig_cycles  = trig_cycles_q;
  assign state        = state_q;

endmodule
`default_nettype wire
